// File: rtl/aes_subbytes_engine.sv
// AES SubBytes / InvSubBytes engine: UNITS S-box lanes are time-multiplexed over a
// WORD_BYTES-wide word, with valid/ready handshakes on both sides.

package aes_gf_pkg;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0), via a short addition chain.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      return gf_mul(gf_mul(x240, x12), x2);
   endfunction

   function automatic logic [7:0] fwd_affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_affine(input logic [7:0] s);
      return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
   endfunction

endpackage

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   import aes_gf_pkg::*;
   assign y = fwd_affine(gf_inv(a));
endmodule

module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   import aes_gf_pkg::*;
   assign y = gf_inv(inv_affine(a));
endmodule

module aes_subbytes_engine #(
   parameter int WORD_BYTES = 16,
   parameter int UNITS      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_inv,
   input  logic [8*WORD_BYTES-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*WORD_BYTES-1:0] out_data,
   output logic                    busy
);
   localparam int PASSES = WORD_BYTES / UNITS;
   localparam int IDX_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

   if ((WORD_BYTES != 4) && (WORD_BYTES != 16)) begin : g_bad_word
      $error("aes_subbytes_engine: WORD_BYTES must be 4 or 16");
   end
   if ((WORD_BYTES % UNITS) != 0) begin : g_bad_units
      $error("aes_subbytes_engine: UNITS must divide WORD_BYTES");
   end

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                  state_q, state_nx;
   logic [IDX_W-1:0]        idx_q;
   logic [8*WORD_BYTES-1:0] work_q, work_nx;
   logic                    inv_q;
   logic                    accept, last_pass;
   logic [7:0]              lane_in  [UNITS];
   logic [7:0]              fwd_y    [UNITS];
   logic [7:0]              inv_y    [UNITS];
   logic [7:0]              lane_out [UNITS];

   assign accept    = (state_q == S_IDLE) && in_valid;
   assign last_pass = (idx_q == IDX_W'(PASSES - 1));

   for (genvar u = 0; u < UNITS; u++) begin : g_lane
      assign lane_in[u] = work_q[8*(int'(idx_q)*UNITS + u) +: 8];
      aes_sbox     u_fwd (.a(lane_in[u]), .y(fwd_y[u]));
      aes_inv_sbox u_inv (.a(lane_in[u]), .y(inv_y[u]));
      assign lane_out[u] = inv_q ? inv_y[u] : fwd_y[u];
   end

   // Substituted bytes are written back in place; the rest of the word holds.
   always_comb begin
      work_nx = work_q;
      for (int u = 0; u < UNITS; u++) begin
         work_nx[8*(int'(idx_q)*UNITS + u) +: 8] = lane_out[u];
      end
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_nx = S_BUSY;
         S_BUSY:  if (last_pass) state_nx = S_DONE;
         S_DONE:  if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         work_q <= '0;
         inv_q  <= 1'b0;
      end else if (accept) begin
         idx_q  <= '0;
         work_q <= in_data;
         inv_q  <= in_inv;
      end else if (state_q == S_BUSY) begin
         idx_q  <= last_pass ? '0 : idx_q + 1'b1;
         work_q <= work_nx;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_BUSY);
   assign out_data  = work_q;

endmodule

// File: tb/tb_aes_subbytes_engine.sv
// Bench for aes_subbytes_engine: three parameterisations checked against a table-driven
// S-box model with directed, exhaustive and randomized words.

module tb_aes_subbytes_engine;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] din;
   logic         din_inv;
   logic [2:0]   iv, ordy;
   logic [2:0]   ir, ov, bz;
   logic [127:0] od_a;
   logic [31:0]  od_b, od_c;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] sbox_t  [256];
   logic [7:0] isbox_t [256];

   always #5 clk = ~clk;

   aes_subbytes_engine u_a (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_inv(din_inv),
      .in_data(din), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od_a), .busy(bz[0])
   );

   aes_subbytes_engine #(.WORD_BYTES(4), .UNITS(1)) u_b (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_inv(din_inv),
      .in_data(din[31:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od_b), .busy(bz[1])
   );

   aes_subbytes_engine #(.WORD_BYTES(4), .UNITS(4)) u_c (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_inv(din_inv),
      .in_data(din[31:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od_c), .busy(bz[2])
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] rol(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   // Forward table from the generator-3 walk over GF(2^8); inverse table by inversion.
   task automatic build_tables();
      logic [7:0] p, q;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         sbox_t[p] = q ^ rol(q, 1) ^ rol(q, 2) ^ rol(q, 3) ^ rol(q, 4) ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
      for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
   endtask

   function automatic logic [127:0] ref_word(input logic [127:0] d, input logic inv, input int upto);
      logic [127:0] r;
      r = d;
      for (int i = 0; i < upto; i++)
         r[8*i +: 8] = inv ? isbox_t[d[8*i +: 8]] : sbox_t[d[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] get_od(input int sel);
      case (sel)
         0:       return od_a;
         1:       return {96'b0, od_b};
         default: return {96'b0, od_c};
      endcase
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic start(input int sel, input logic [127:0] d, input logic inv);
      int n;
      n = 0;
      while (!ir[sel] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("ready_timeout", 128'(ir[sel]), 128'(1));
      din = d;
      din_inv = inv;
      iv[sel] = 1'b1;
      @(posedge clk); #1;
      iv[sel] = 1'b0;
   endtask

   // Inputs are scrambled every cycle while the word is in flight.
   task automatic wait_done(input int sel, output int lat, output int bcnt);
      lat = 0;
      bcnt = 0;
      while (!ov[sel] && lat < 50) begin
         if (bz[sel]) bcnt++;
         din = rnd128();
         din_inv = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take(input int sel);
      ordy[sel] = 1'b1;
      @(posedge clk); #1;
      ordy[sel] = 1'b0;
   endtask

   task automatic run(input int sel, input logic [127:0] d, input logic inv,
                      output logic [127:0] res, output int lat, output int bcnt);
      start(sel, d, inv);
      wait_done(sel, lat, bcnt);
      res = get_od(sel);
      take(sel);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [127:0] d, w, r, r2, held;
      logic         inv;
      int           lat, bc;

      build_tables();
      iv = '0;
      ordy = '0;
      din = '0;
      din_inv = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 128'(ir), 128'(3'b111));
      chk("rst_out_valid", 128'(ov), 128'(0));
      chk("rst_busy", 128'(bz), 128'(0));
      chk("rst_out_data", od_a, 128'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed forward word on the default build.
      d = {8'hff, 112'h0, 8'h53};
      run(0, d, 1'b0, r, lat, bc);
      chk("fwd_latency", 128'(lat), 128'(4));
      chk("fwd_data", r, {8'h16, {14{8'h63}}, 8'hed});
      chk("fwd_model", r, ref_word(d, 1'b0, 16));

      // Directed inverse word, one lane.
      run(1, 128'h00ed6300, 1'b1, r, lat, bc);
      chk("inv_latency", 128'(lat), 128'(4));
      chk("inv_busy_cycles", 128'(bc), 128'(4));
      chk("inv_data", r, 128'h52530052);

      // All byte values replicated across four lanes, forward then inverse.
      for (int v = 0; v < 256; v++) begin
         w = {96'b0, {4{8'(v)}}};
         run(2, w, 1'b0, r, lat, bc);
         if (v == 0) begin
            chk("single_pass_latency", 128'(lat), 128'(1));
            chk("single_pass_busy", 128'(bc), 128'(1));
         end
         chk("sweep_fwd", r, ref_word(w, 1'b0, 4));
         run(2, r, 1'b1, r2, lat, bc);
         chk("sweep_roundtrip", r2, w);
      end

      // Randomized words on both multi-pass builds.
      for (int k = 0; k < 16; k++) begin
         d = rnd128();
         inv = 1'($urandom);
         run(0, d, inv, r, lat, bc);
         chk("rand16_data", r, ref_word(d, inv, 16));
         d = {96'b0, $urandom};
         inv = 1'($urandom);
         run(1, d, inv, r, lat, bc);
         chk("rand4_data", r, ref_word(d, inv, 4));
      end

      // Back-pressure with a new word waiting.
      w = rnd128();
      start(0, w, 1'b0);
      wait_done(0, lat, bc);
      held = od_a;
      chk("bp_first_data", held, ref_word(w, 1'b0, 16));
      d = rnd128();
      din = d;
      din_inv = 1'b1;
      iv[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk("bp_hold_data", od_a, held);
         chk("bp_in_ready_low", 128'(ir[0]), 128'(0));
         chk("bp_out_valid_high", 128'(ov[0]), 128'(1));
      end
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      chk("bp_in_ready_after", 128'(ir[0]), 128'(1));
      @(posedge clk); #1;
      iv[0] = 1'b0;
      chk("bp_accepted", 128'(bz[0]), 128'(1));
      wait_done(0, lat, bc);
      chk("bp_second_latency", 128'(lat), 128'(4));
      chk("bp_second_data", od_a, ref_word(d, 1'b1, 16));
      take(0);

      // Asynchronous reset while pass 2 of 4 is pending.
      w = rnd128();
      start(0, w, 1'b0);
      @(posedge clk); #1;
      chk("partial_low_first", od_a, ref_word(w, 1'b0, 4));
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 128'(ov[0]), 128'(0));
      chk("midrst_busy", 128'(bz[0]), 128'(0));
      chk("midrst_in_ready", 128'(ir[0]), 128'(1));
      chk("midrst_out_data", od_a, 128'(0));
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      d = rnd128();
      run(0, d, 1'b1, r, lat, bc);
      chk("postrst_latency", 128'(lat), 128'(4));
      chk("postrst_data", r, ref_word(d, 1'b1, 16));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
